// File: rtl/shiftreg_seq.sv
// rtl/shiftreg_seq.sv - serial-load sequencer and readback checker for a shift register
//
// Takes a parallel word over a start_valid/start_ready handshake, shifts it into
// an external serial-in shift register one bit per clock, then compares the
// register's parallel output with the word and reports the result.
//
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   start_valid  request to load word/dir_cfg
//   start_ready  idle, request will be accepted
//   word         word to shift into the register
//   dir_cfg      0: shift toward MSB (MSB first); 1: toward LSB (LSB first)
//   abort        cancel an in-flight transfer
//   sr_data      serial bit to the register
//   sr_en        shift enable to the register
//   sr_dir       shift direction to the register
//   sr_q         parallel output fed back from the register
//   busy         transfer in progress (SHIFT or CHECK)
//   done         one-cycle pulse when a transfer finishes or is aborted
//   ok           result of the last transfer, valid from done

module shiftreg_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] word,
    input  logic             dir_cfg,
    input  logic             abort,
    output logic             sr_data,
    output logic             sr_en,
    output logic             sr_dir,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy,
    output logic             done,
    output logic             ok
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] word_l, word_d;
    logic             dir_l, dir_d;
    logic             sr_data_d, sr_en_d, sr_dir_d;
    logic             busy_d, done_d, ok_d, ready_d;
    logic [CW-1:0]    nxt_idx;

    // Index of the bit presented after the current one; dir 0 walks down from
    // the MSB, dir 1 walks up from the LSB.
    assign nxt_idx = cnt + CW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            word_l      <= '0;
            dir_l       <= 1'b0;
            sr_data     <= 1'b0;
            sr_en       <= 1'b0;
            sr_dir      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ok          <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            word_l      <= word_d;
            dir_l       <= dir_d;
            sr_data     <= sr_data_d;
            sr_en       <= sr_en_d;
            sr_dir      <= sr_dir_d;
            busy        <= busy_d;
            done        <= done_d;
            ok          <= ok_d;
            start_ready <= ready_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        word_d    = word_l;
        dir_d     = dir_l;
        sr_data_d = sr_data;
        sr_en_d   = sr_en;
        sr_dir_d  = sr_dir;
        busy_d    = busy;
        done_d    = 1'b0;
        ok_d      = ok;
        ready_d   = start_ready;

        case (state)
            S_IDLE: begin
                if (start_valid && start_ready) begin
                    word_d    = word;
                    dir_d     = dir_cfg;
                    sr_dir_d  = dir_cfg;
                    sr_en_d   = 1'b1;
                    sr_data_d = dir_cfg ? word[0] : word[WIDTH-1];
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    sr_en_d   = 1'b0;
                    sr_data_d = 1'b0;
                    ok_d      = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else if (cnt == LAST) begin
                    // Register takes the final bit on this edge.
                    sr_en_d   = 1'b0;
                    sr_data_d = 1'b0;
                    state_d   = S_CHECK;
                end else begin
                    cnt_d     = nxt_idx;
                    sr_data_d = dir_l ? word_l[nxt_idx] : word_l[LAST - nxt_idx];
                end
            end
            S_CHECK: begin
                // abort takes priority over the compare result
                ok_d    = abort ? 1'b0 : (sr_q == word_l);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                sr_en_d   = 1'b0;
                sr_data_d = 1'b0;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

endmodule
